afe_a2d: RTL and testbench

Behavioural analog-front-end and A2D model that sits beside the digital oscilloscope core on the shared SPI bus. It holds four write-only SPI-programmed digital potentiometers: three channel gains and one trigger level. It generates three 8-bit sampled channels paced by `adc_clk`, scaled by each channel's gain wiper, and drives two trigger comparator outputs.

---
 rtl/afe_a2d.sv | 210 +++++++++++++++++++++
 tb/tb_afe_a2d.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/afe_a2d.sv
// Behavioural AFE + A2D: four SPI-programmed digital pots (three channel
// gains, one trigger level), three scaled triangle channels and two comparators.

module afe_a2d_spi_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk_i,
   input  logic        mosi_i,
   input  logic        ss_n_i,
   output logic [15:0] frame_o,
   output logic        frame_ok_o
);
   logic [2:0]  sclk_q;
   logic [2:0]  ss_q;
   logic [1:0]  mosi_q;
   logic [15:0] shift_q, shift_d;
   logic [15:0] cmd_rcvd, cmd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sclk_rise, ss_rise, ss_fall;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];

   // Only an exact 16-bit frame is accepted; longer or shorter is dropped.
   assign frame_ok_o = ss_rise && (cnt_q == 5'd16);
   assign frame_o    = shift_q;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_rcvd;
      if (ss_fall) begin
         cnt_d = 5'd0;
      end else if (sclk_rise && !ss_q[1]) begin
         shift_d = {shift_q[14:0], mosi_q[1]};
         if (cnt_q != 5'd31)
            cnt_d = cnt_q + 5'd1;
      end
      if (frame_ok_o)
         cmd_d = shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q   <= 3'b111;
         ss_q     <= 3'b111;
         mosi_q   <= 2'b00;
         shift_q  <= 16'h0000;
         cnt_q    <= 5'd0;
         cmd_rcvd <= 16'h0000;
      end else begin
         sclk_q   <= {sclk_q[1:0], sclk_i};
         ss_q     <= {ss_q[1:0], ss_n_i};
         mosi_q   <= {mosi_q[0], mosi_i};
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         cmd_rcvd <= cmd_d;
      end
   end
endmodule

module afe_a2d_pot #(
   parameter logic [7:0] WIPER_RST = 8'h20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_i,
   input  logic       mosi_i,
   input  logic       ss_n_i,
   output logic [7:0] wiper_o
);
   logic [15:0] frame;
   logic        frame_ok;
   logic [7:0]  wiper_q, wiper_d;

   afe_a2d_spi_rx iCHX_CFG (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk_i     (sclk_i),
      .mosi_i     (mosi_i),
      .ss_n_i     (ss_n_i),
      .frame_o    (frame),
      .frame_ok_o (frame_ok)
   );

   always_comb begin
      wiper_d = wiper_q;
      if (frame_ok && frame[15:8] == 8'h13)
         wiper_d = frame[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wiper_q <= WIPER_RST;
      else        wiper_q <= wiper_d;
   end

   assign wiper_o = wiper_q;
endmodule

module afe_a2d #(
   parameter int unsigned CH1_STEP = 1,
   parameter int unsigned CH2_STEP = 2,
   parameter int unsigned CH3_STEP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adc_clk,
   input  logic       ch1_ss_n,
   input  logic       ch2_ss_n,
   input  logic       ch3_ss_n,
   input  logic       trig_ss_n,
   input  logic       MOSI,
   input  logic       SCLK,
   output logic [7:0] ch1_data,
   output logic [7:0] ch2_data,
   output logic [7:0] ch3_data,
   output logic       trig1,
   output logic       trig2
);
   localparam logic [7:0] STEP [3] = '{8'(CH1_STEP), 8'(CH2_STEP), 8'(CH3_STEP)};

   logic [7:0] wip [3];
   logic [7:0] lvl;
   logic [2:0] adc_q;
   logic       adc_rise;
   logic [7:0] src_q [3];
   logic [7:0] src_d [3];
   logic [2:0] up_q, up_d;
   logic [7:0] dat_q [3];
   logic [7:0] dat_d [3];
   logic [8:0] sum;
   logic       trig1_q, trig2_q;

   afe_a2d_pot #(.WIPER_RST(8'h20)) POT1 (
      .clk(clk), .rst_n(rst_n), .sclk_i(SCLK), .mosi_i(MOSI),
      .ss_n_i(ch1_ss_n), .wiper_o(wip[0]));
   afe_a2d_pot #(.WIPER_RST(8'h20)) POT2 (
      .clk(clk), .rst_n(rst_n), .sclk_i(SCLK), .mosi_i(MOSI),
      .ss_n_i(ch2_ss_n), .wiper_o(wip[1]));
   afe_a2d_pot #(.WIPER_RST(8'h20)) POT3 (
      .clk(clk), .rst_n(rst_n), .sclk_i(SCLK), .mosi_i(MOSI),
      .ss_n_i(ch3_ss_n), .wiper_o(wip[2]));
   afe_a2d_pot #(.WIPER_RST(8'h80)) POTT (
      .clk(clk), .rst_n(rst_n), .sclk_i(SCLK), .mosi_i(MOSI),
      .ss_n_i(trig_ss_n), .wiper_o(lvl));

   assign adc_rise = adc_q[1] & ~adc_q[2];

   // Wiper 0x20 is unity: (d * w) >>> 5, clamped back into offset binary.
   function automatic logic [7:0] scale(input logic [7:0] s, input logic [7:0] w);
      logic signed [8:0]  d;
      logic signed [17:0] p;
      d = $signed({1'b0, s}) - 9'sd128;
      p = (d * $signed({1'b0, w})) >>> 5;
      if (p > 18'sd127)       return 8'hFF;
      else if (p < -18'sd128) return 8'h00;
      else                    return p[7:0] ^ 8'h80;
   endfunction

   always_comb begin
      up_d = up_q;
      sum  = 9'd0;
      for (int i = 0; i < 3; i++) begin
         src_d[i] = src_q[i];
         dat_d[i] = dat_q[i];
         sum      = {1'b0, src_q[i]} + {1'b0, STEP[i]};
         if (adc_rise) begin
            if (up_q[i]) begin
               if (sum >= 9'h0FF) begin
                  src_d[i] = 8'hFF;
                  up_d[i]  = 1'b0;
               end else begin
                  src_d[i] = sum[7:0];
               end
            end else if (src_q[i] <= STEP[i]) begin
               src_d[i] = 8'h00;
               up_d[i]  = 1'b1;
            end else begin
               src_d[i] = src_q[i] - STEP[i];
            end
            dat_d[i] = scale(src_d[i], wip[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adc_q   <= 3'b000;
         src_q   <= '{default: 8'h80};
         up_q    <= 3'b111;
         dat_q   <= '{default: 8'h80};
         trig1_q <= 1'b0;
         trig2_q <= 1'b0;
      end else begin
         adc_q   <= {adc_q[1:0], adc_clk};
         src_q   <= src_d;
         up_q    <= up_d;
         dat_q   <= dat_d;
         trig1_q <= dat_q[0] > lvl;
         trig2_q <= dat_q[1] > lvl;
      end
   end

   assign ch1_data = dat_q[0];
   assign ch2_data = dat_q[1];
   assign ch3_data = dat_q[2];
   assign trig1    = trig1_q;
   assign trig2    = trig2_q;
endmodule

// File: tb/tb_afe_a2d.sv
// Directed bench for afe_a2d: pot programming, frame rejection,
// channel scaling/saturation and trigger timing.

module tb_afe_a2d;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       adc_clk = 1'b0;
   logic       ch1_ss_n = 1'b1;
   logic       ch2_ss_n = 1'b1;
   logic       ch3_ss_n = 1'b1;
   logic       trig_ss_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       SCLK = 1'b1;
   logic [7:0] ch1_data, ch2_data, ch3_data;
   logic       trig1, trig2;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   afe_a2d dut (
      .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk),
      .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n),
      .ch3_ss_n(ch3_ss_n), .trig_ss_n(trig_ss_n),
      .MOSI(MOSI), .SCLK(SCLK),
      .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
      .trig1(trig1), .trig2(trig2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sel(input logic [3:0] s);
      {trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n} = ~s;
   endtask

   task automatic bits(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         SCLK = 1'b0;
         MOSI = v[15-i];
         repeat (4) @(negedge clk);
         SCLK = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic spi(input logic [3:0] s, input logic [15:0] v, input int n);
      @(negedge clk);
      sel(s);
      repeat (4) @(negedge clk);
      bits(v, n);
      sel(4'b0000);
      repeat (6) @(negedge clk);
   endtask

   task automatic pulse_hi;
      @(negedge clk);
      adc_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_lo;
      @(negedge clk);
      adc_clk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [7:0] mdl(input int src, input int w);
      int p;
      p = ((src - 128) * w) >>> 5;
      if (p > 127) p = 127;
      if (p < -128) p = -128;
      return 8'(p + 128);
   endfunction

   initial begin
      logic [7:0] e1, e2;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_cmd1", dut.POT1.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("rst_cmd2", dut.POT2.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("rst_cmd3", dut.POT3.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("rst_cmdt", dut.POTT.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("rst_ch1", ch1_data, 8'h80);
      chk("rst_ch2", ch2_data, 8'h80);
      chk("rst_ch3", ch3_data, 8'h80);
      chk("rst_trig1", trig1, 1'b0);
      chk("rst_trig2", trig2, 1'b0);
      chk("rst_wipt", dut.POTT.wiper_q, 8'h80);

      // unity gain ramp
      for (int k = 1; k <= 4; k++) begin
         pulse_hi();
         chk("ramp_ch1", ch1_data, 8'(8'h80 + k));
         pulse_lo();
      end
      chk("ramp_ch2", ch2_data, 8'h88);
      chk("ramp_ch3", ch3_data, 8'h90);

      spi(4'b0001, 16'h1302, 16);
      chk("p1_cmd", dut.POT1.iCHX_CFG.cmd_rcvd, 16'h1302);
      chk("p1_wip", dut.POT1.wiper_q, 8'h02);
      chk("p2_idle", dut.POT2.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("p3_idle", dut.POT3.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("pt_idle", dut.POTT.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("p2_wip_idle", dut.POT2.wiper_q, 8'h20);

      spi(4'b0010, 16'h1305, 16);
      spi(4'b0100, 16'h1309, 16);
      spi(4'b0010, 16'h1328, 16);
      spi(4'b0001, 16'h1346, 16);
      spi(4'b0100, 16'h13DD, 16);
      chk("seq_cmd1", dut.POT1.iCHX_CFG.cmd_rcvd, 16'h1346);
      chk("seq_cmd2", dut.POT2.iCHX_CFG.cmd_rcvd, 16'h1328);
      chk("seq_cmd3", dut.POT3.iCHX_CFG.cmd_rcvd, 16'h13DD);
      chk("seq_wip3", dut.POT3.wiper_q, 8'hDD);

      spi(4'b0010, 16'hABCD, 12);
      chk("short_cmd2", dut.POT2.iCHX_CFG.cmd_rcvd, 16'h1328);
      spi(4'b0010, 16'h1140, 16);
      chk("bad_op_cmd2", dut.POT2.iCHX_CFG.cmd_rcvd, 16'h1140);
      chk("bad_op_wip2", dut.POT2.wiper_q, 8'h28);

      // gains now 0x46 / 0x28 / 0xDD
      pulse_hi();
      chk("gain_ch1", ch1_data, 8'h8A);
      chk("gain_ch2", ch2_data, 8'h8C);
      chk("sat_ch3", ch3_data, 8'hFF);
      pulse_lo();

      spi(4'b1000, 16'h1390, 16);
      spi(4'b0001, 16'h1320, 16);
      chk("lvl_wip", dut.POTT.wiper_q, 8'h90);
      chk("lvl_trig1", trig1, 1'b0);
      chk("lvl_trig2", trig2, 1'b0);

      for (int i = 0; i < 12; i++) begin
         e1 = 8'(8'h86 + i);
         e2 = mdl(8'h8C + 2 * i, 8'h28);
         pulse_hi();
         chk("trg_ch1", ch1_data, e1);
         chk("trg_ch2", ch2_data, e2);
         if (e1 == 8'h91)
            chk("trg1_lag", trig1, 1'b0);
         @(posedge clk);
         #1;
         chk("trg1", trig1, e1 > 8'h90);
         chk("trg2", trig2, e2 > 8'h90);
         pulse_lo();
      end

      // reset mid-frame must drop the frame
      @(negedge clk);
      sel(4'b0010);
      repeat (4) @(negedge clk);
      bits(16'h13AA, 8);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bits(16'hAA00, 8);
      sel(4'b0000);
      repeat (6) @(negedge clk);
      chk("abort_cmd2", dut.POT2.iCHX_CFG.cmd_rcvd, 16'h0000);
      chk("abort_wip2", dut.POT2.wiper_q, 8'h20);
      chk("abort_ch1", ch1_data, 8'h80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
